// File: rtl/fp_pkg.sv
// Shared definitions for the custom-float unpack path: class encodings,
// the exponent bias and field slicing for packed {sign, exponent, mantissa} words.
package fp_pkg;

    typedef enum logic [1:0] {
        CLASS_ZERO = 2'd0,
        CLASS_NORM = 2'd1,
        CLASS_INF  = 2'd2,
        CLASS_NAN  = 2'd3
    } fp_class_e;

    function automatic int exp_const(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

    // Helpers take the word zero-extended to 64 bits so one definition
    // serves every format width up to 64.
    function automatic logic fp_sign(input logic [63:0] word, input int in_width);
        return word[in_width-1];
    endfunction

    function automatic logic [31:0] fp_exp(input logic [63:0] word, input int exp_width,
                                           input int man_width);
        return 32'((word >> man_width) & ((64'd1 << exp_width) - 64'd1));
    endfunction

    function automatic logic [63:0] fp_man(input logic [63:0] word, input int man_width);
        return word & ((64'd1 << man_width) - 64'd1);
    endfunction

endpackage

// File: rtl/fp_unpack_arbiter_if.sv
// Request and result bus of the shared unpacker; slave is the DUT side,
// master is the requester/consumer side.
interface fp_unpack_arbiter_if #(
    parameter int ExpWidth = 8,
    parameter int ManWidth = 23,
    parameter int InWidth  = 32,
    parameter int NumReq   = 4,
    parameter int IdWidth  = 2
);
    // Handshakes: a request is accepted in the cycle DataNd_i[k] && Ack_o[k];
    // a result transfers in the cycle Valid_o && Rdy_i, and all result fields
    // hold while Valid_o && !Rdy_i.
    logic [NumReq*InWidth-1:0] Data_i;
    logic [NumReq-1:0]         DataNd_i;
    logic [NumReq-1:0]         Ack_o;
    logic                      Rdy_i;
    logic                      Valid_o;
    logic [IdWidth-1:0]        Id_o;
    logic                      Sign_o;
    logic signed [ExpWidth+1:0] Exp_o;
    logic [ManWidth:0]         Man_o;
    logic [1:0]                Class_o;
    logic                      Busy_o;
    logic [IdWidth-1:0]        DbgPtr_o;

    modport slave (
        input  Data_i, DataNd_i, Rdy_i,
        output Ack_o, Valid_o, Id_o, Sign_o, Exp_o, Man_o, Class_o, Busy_o, DbgPtr_o
    );

    modport master (
        output Data_i, DataNd_i, Rdy_i,
        input  Ack_o, Valid_o, Id_o, Sign_o, Exp_o, Man_o, Class_o, Busy_o, DbgPtr_o
    );
endinterface

// File: rtl/fp_unpack.sv
// Combinational decoder: packed custom-float word to sign, unbiased exponent,
// mantissa with hidden bit, and class. Subnormals flush to zero.
module fp_unpack
    import fp_pkg::*;
#(
    parameter int ExpWidth = 8,
    parameter int ManWidth = 23,
    parameter int InWidth  = 32
) (
    input  logic [InWidth-1:0]     word,
    output logic                   sign,
    output logic signed [ExpWidth+1:0] exp_unb,
    output logic [ManWidth:0]      man,
    output fp_class_e              cls
);

    logic [ExpWidth-1:0] exp_field;
    logic [ManWidth-1:0] frac;

    assign sign      = fp_sign(64'(word), InWidth);
    assign exp_field = ExpWidth'(fp_exp(64'(word), ExpWidth, ManWidth));
    assign frac      = ManWidth'(fp_man(64'(word), ManWidth));

    always_comb begin
        cls     = CLASS_NORM;
        exp_unb = '0;
        man     = {1'b1, frac};
        if (exp_field == '0) begin
            cls = CLASS_ZERO;
            man = '0;
        end else if (&exp_field) begin
            cls = (frac == '0) ? CLASS_INF : CLASS_NAN;
        end else begin
            exp_unb = $signed({2'b00, exp_field})
                    - $signed((ExpWidth+2)'(exp_const(ExpWidth)));
        end
    end

endmodule

// File: rtl/fp_unpack_arbiter.sv
// Round-robin front end sharing one two-stage unpack pipeline between NumReq
// requesters; results carry the index of the requester they came from.
module fp_unpack_arbiter
    import fp_pkg::*;
#(
    parameter int ExpWidth = 8,
    parameter int ManWidth = 23,
    parameter int InWidth  = 32,
    parameter int NumReq   = 4,
    parameter int IdWidth  = 2
) (
    input logic             Clk_i,
    input logic             Rst_i,
    fp_unpack_arbiter_if.slave bus
);

    logic                       s1_valid;
    logic [InWidth-1:0]         s1_word;
    logic [IdWidth-1:0]         s1_id;
    logic [IdWidth-1:0]         ptr;

    logic                       s2_valid;
    logic [IdWidth-1:0]         s2_id;
    logic                       s2_sign;
    logic signed [ExpWidth+1:0] s2_exp;
    logic [ManWidth:0]          s2_man;
    fp_class_e                  s2_cls;

    logic                       dec_sign;
    logic signed [ExpWidth+1:0] dec_exp;
    logic [ManWidth:0]          dec_man;
    fp_class_e                  dec_cls;

    logic                       s2_ready;
    logic                       s1_ready;
    logic                       req_found;
    logic                       grant;
    logic [IdWidth-1:0]         grant_idx;
    logic [IdWidth-1:0]         next_ptr;
    int                         scan;

    // S1 may take a new word if it is empty or hands its word to S2 this cycle,
    // which lets a final pop and a new grant share one cycle.
    assign s2_ready = !s2_valid || bus.Rdy_i;
    assign s1_ready = !s1_valid || s2_ready;

    always_comb begin
        req_found = 1'b0;
        grant_idx = '0;
        scan      = 0;
        for (int i = 0; i < NumReq; i++) begin
            scan = (int'(ptr) + i) % NumReq;
            if (!req_found && bus.DataNd_i[scan]) begin
                req_found = 1'b1;
                grant_idx = IdWidth'(scan);
            end
        end
    end

    assign grant    = req_found && s1_ready && !Rst_i;
    assign next_ptr = IdWidth'((int'(grant_idx) + 1) % NumReq);
    assign bus.Ack_o = grant ? (NumReq'(1) << grant_idx) : '0;

    fp_unpack #(
        .ExpWidth (ExpWidth),
        .ManWidth (ManWidth),
        .InWidth  (InWidth)
    ) u_unpack (
        .word    (s1_word),
        .sign    (dec_sign),
        .exp_unb (dec_exp),
        .man     (dec_man),
        .cls     (dec_cls)
    );

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
            s1_id    <= '0;
            ptr      <= '0;
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_sign  <= 1'b0;
            s2_exp   <= '0;
            s2_man   <= '0;
            s2_cls   <= CLASS_ZERO;
        end else begin
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_id   <= s1_id;
                    s2_sign <= dec_sign;
                    s2_exp  <= dec_exp;
                    s2_man  <= dec_man;
                    s2_cls  <= dec_cls;
                end
            end
            if (s1_ready) begin
                s1_valid <= grant;
                if (grant) begin
                    s1_word <= bus.Data_i[int'(grant_idx)*InWidth +: InWidth];
                    s1_id   <= grant_idx;
                    ptr     <= next_ptr;
                end
            end
        end
    end

    assign bus.Valid_o  = s2_valid;
    assign bus.Id_o     = s2_id;
    assign bus.Sign_o   = s2_sign;
    assign bus.Exp_o    = s2_exp;
    assign bus.Man_o    = s2_man;
    assign bus.Class_o  = s2_cls;
    assign bus.Busy_o   = s1_valid || s2_valid;
    assign bus.DbgPtr_o = ptr;

endmodule

// File: tb/tb_fp_unpack_arbiter.sv
// Directed bench for fp_unpack_arbiter: single decodes, round-robin order,
// output stall and mid-flight reset, checked against a queue of expected results.
module tb_fp_unpack_arbiter;
  import fp_pkg::*;

  localparam int EW  = 8;
  localparam int MW  = 23;
  localparam int IW  = 32;
  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int RW  = IDW + 1 + (EW + 2) + (MW + 1) + 2;

  // ---------------- clock / reset ----------------
  logic Clk_i = 1'b0;
  logic Rst_i = 1'b1;
  always #5 Clk_i = ~Clk_i;

  fp_unpack_arbiter_if #(
    .ExpWidth(EW), .ManWidth(MW), .InWidth(IW), .NumReq(NR), .IdWidth(IDW)
  ) bus ();

  fp_unpack_arbiter #(
    .ExpWidth(EW), .ManWidth(MW), .InWidth(IW), .NumReq(NR), .IdWidth(IDW)
  ) dut (
    .Clk_i (Clk_i),
    .Rst_i (Rst_i),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- vectors (hand-decoded) ----------------
  typedef struct {
    int                id;
    logic [31:0]       word;
    logic              sign;
    logic signed [9:0] exp;
    logic [23:0]       man;
    logic [1:0]        cls;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{0, 32'h3F80_0000, 1'b0,  10'sd0,   24'h80_0000, 2'd1};
    vecs[1] = '{1, 32'h0080_0000, 1'b0, -10'sd126, 24'h80_0000, 2'd1};
    vecs[2] = '{2, 32'hC040_0000, 1'b1,  10'sd1,   24'hC0_0000, 2'd1};
    vecs[3] = '{3, 32'h7F80_0000, 1'b0,  10'sd0,   24'h80_0000, 2'd2};
    vecs[4] = '{0, 32'hFFC0_0000, 1'b1,  10'sd0,   24'hC0_0000, 2'd3};
    vecs[5] = '{1, 32'h0000_0001, 1'b0,  10'sd0,   24'h00_0000, 2'd0};
    vecs[6] = '{2, 32'h8000_0000, 1'b1,  10'sd0,   24'h00_0000, 2'd0};
    vecs[7] = '{3, 32'h4049_0FDB, 1'b0,  10'sd1,   24'hC9_0FDB, 2'd1};
    vecs[8] = '{0, 32'h7F7F_FFFF, 1'b0,  10'sd127, 24'hFF_FFFF, 2'd1};
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] pack_vec(input int v);
    return {IDW'(vecs[v].id), vecs[v].sign, vecs[v].exp, vecs[v].man, vecs[v].cls};
  endfunction

  function automatic logic [RW-1:0] observed();
    return {bus.Id_o, bus.Sign_o, bus.Exp_o, bus.Man_o, bus.Class_o};
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a negedge: retire any result transferring this cycle,
  // then advance to the next negedge.
  task automatic tick();
    if (bus.Valid_o && bus.Rdy_i) begin
      if (exp_q.size() == 0) check("unexpected_result", 64'(exp_q.size()), 64'(1));
      else check("result", 64'(observed()), 64'(exp_q.pop_front()));
    end
    @(posedge Clk_i);
    @(negedge Clk_i);
  endtask

  task automatic set_word(input int k, input logic [31:0] w);
    bus.Data_i[k*IW +: IW] = w;
  endtask

  task automatic drain(input string tag);
    bus.DataNd_i = '0;
    bus.Rdy_i    = 1'b1;
    #1;
    for (int i = 0; i < 12 && (exp_q.size() != 0 || bus.Valid_o); i++) tick();
    #1;
    check({tag, "_left"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_busy"}, 64'(bus.Busy_o), 64'(0));
  endtask

  task automatic do_reset();
    Rst_i        = 1'b1;
    bus.DataNd_i = '0;
    exp_q.delete();
    tick();
    tick();
    Rst_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int  stall_idx[9] = '{0, 1, -1, -1, -1, 2, 3, 0, 1};
  logic stall_rdy[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    bus.Data_i   = '0;
    bus.DataNd_i = '0;
    bus.Rdy_i    = 1'b1;
    Rst_i        = 1'b1;
    repeat (3) @(negedge Clk_i);
    bus.DataNd_i = 4'b1111;
    #1;
    check("rst_ack",   64'(bus.Ack_o),    64'(0));
    check("rst_valid", 64'(bus.Valid_o),  64'(0));
    check("rst_busy",  64'(bus.Busy_o),   64'(0));
    check("rst_ptr",   64'(bus.DbgPtr_o), 64'(0));
    check("rst_fields", 64'(observed()),  64'(0));
    bus.DataNd_i = '0;
    Rst_i        = 1'b0;
    tick();

    // Single requests: ack at N, result at N+2.
    for (int v = 0; v < 9; v++) begin
      set_word(vecs[v].id, vecs[v].word);
      bus.DataNd_i = NR'(1) << vecs[v].id;
      #1;
      check($sformatf("single%0d_ack", v), 64'(bus.Ack_o), 64'(1) << vecs[v].id);
      exp_q.push_back(pack_vec(v));
      tick();
      bus.DataNd_i = '0;
      check($sformatf("single%0d_n1_valid", v), 64'(bus.Valid_o), 64'(0));
      tick();
      check($sformatf("single%0d_n2_valid", v), 64'(bus.Valid_o), 64'(1));
      tick();
    end
    drain("single_drain");

    // Round-robin with all four requesting continuously.
    do_reset();
    for (int k = 0; k < NR; k++) set_word(k, vecs[k].word);
    bus.DataNd_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr%0d_ack", i), 64'(bus.Ack_o), 64'(1) << (i % NR));
      exp_q.push_back(pack_vec(i % NR));
      tick();
    end
    drain("rr_drain");

    // Stall: Rdy_i low for five cycles while all requesters wait.
    bus.DataNd_i = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      bus.Rdy_i = stall_rdy[i];
      #1;
      if (stall_idx[i] < 0) begin
        check($sformatf("stall%0d_ack", i), 64'(bus.Ack_o), 64'(0));
        check($sformatf("stall%0d_frozen", i), 64'(observed()), 64'(exp_q[0]));
        check($sformatf("stall%0d_valid", i), 64'(bus.Valid_o), 64'(1));
        check($sformatf("stall%0d_inflight", i), 64'(exp_q.size()), 64'(2));
      end else begin
        check($sformatf("stall%0d_ack", i), 64'(bus.Ack_o), 64'(1) << stall_idx[i]);
        exp_q.push_back(pack_vec(stall_idx[i]));
      end
      tick();
    end
    drain("stall_drain");

    // Reset with both stages full; earlier grant left the pointer non-zero.
    bus.Rdy_i    = 1'b0;
    bus.DataNd_i = 4'b1100;
    #1;
    check("fill_ack0", 64'(bus.Ack_o), 64'(4'b0100));
    tick();
    #1;
    check("fill_ack1", 64'(bus.Ack_o), 64'(4'b1000));
    tick();
    #1;
    check("fill_busy",  64'(bus.Busy_o),  64'(1));
    check("fill_valid", 64'(bus.Valid_o), 64'(1));
    Rst_i = 1'b1;
    #1;
    check("midrst_ack", 64'(bus.Ack_o), 64'(0));
    tick();
    Rst_i        = 1'b0;
    bus.DataNd_i = '0;
    exp_q.delete();
    #1;
    check("midrst_valid", 64'(bus.Valid_o),  64'(0));
    check("midrst_busy",  64'(bus.Busy_o),   64'(0));
    check("midrst_ptr",   64'(bus.DbgPtr_o), 64'(0));
    bus.Rdy_i    = 1'b1;
    bus.DataNd_i = 4'b1010;
    #1;
    check("post_rst_ack0", 64'(bus.Ack_o), 64'(4'b0010));
    exp_q.push_back(pack_vec(1));
    tick();
    #1;
    check("post_rst_ack1", 64'(bus.Ack_o), 64'(4'b1000));
    exp_q.push_back(pack_vec(3));
    tick();
    drain("post_rst_drain");

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_unpack_arbiter.md
Name: fp_unpack_arbiter

Overview:
Shares one pipelined custom-float unpack unit between NumReq requesters. Each requester submits a packed word of the form {sign, exponent, mantissa}. A round-robin arbiter grants one request per cycle. The unpacker classifies the word, removes the exponent bias, restores the hidden bit, and returns the result tagged with the requester index. It is the synthesizable front end that sits ahead of the real-valued monitors and the arithmetic consumers.

Parameters:
ExpWidth, 8, exponent field width
ManWidth, 23, stored mantissa width
InWidth, 32, packed word width; must equal 1+ExpWidth+ManWidth
NumReq, 4, number of requesters (2..16)
IdWidth, 2, clog2(NumReq)

Ports:
Clk_i  in  1  clock
Rst_i  in  1  synchronous active-high reset
Data_i  in  NumReq*InWidth  packed request words; requester k occupies bits [k*InWidth +: InWidth]
DataNd_i  in  NumReq  request valid, one bit per requester
Ack_o  out  NumReq  one-hot, one-cycle accept pulse
Rdy_i  in  1  downstream ready
Valid_o  out  1  result valid
Id_o  out  IdWidth  requester index of the result
Sign_o  out  1  sign bit
Exp_o  out  ExpWidth+2  signed, unbiased exponent
Man_o  out  ManWidth+1  mantissa including the hidden bit
Class_o  out  2  0 zero, 1 normal, 2 inf, 3 nan
Busy_o  out  1  any pipeline stage holds data

Behaviour:
- Clocking and reset: single clock, Clk_i. Reset is synchronous and active-high on Rst_i.
- Reset values: all outputs 0. Both stage valids are 0. Round-robin pointer is 0.
- Request handshake:
  - A requester raises DataNd_i[k] and holds Data_i slice k stable until it sees Ack_o[k].
  - Ack_o[k] is high for exactly one cycle; that cycle is the capture cycle.
  - A requester may drop its request before it is acked, with no side effects.
- Arbitration:
  - The arbiter grants only when stage 1 can accept: stage 1 is empty, or stage 1 is advancing this cycle.
  - Search order starts at the pointer and wraps modulo NumReq.
  - After a grant to index g, the pointer becomes (g+1) mod NumReq.
  - The pointer does not change when there is no grant.
- Pipeline, two stages:
  - S1 registers the captured word and its Id.
  - S2 registers the decoded result, which drives the outputs directly.
  - Latency: a word acked in cycle N appears on Valid_o in cycle N+2 when there is no stall.
  - Throughput: one result per cycle.
- Stall:
  - While Valid_o=1 and Rdy_i=0, S2 holds its contents and every output is stable.
  - S1 advances only into an empty or advancing S2. With S1 full and blocked, no Ack_o is issued.
- Decode (ExpConst = 2^(ExpWidth-1)-1):
  - exp==0: Class 0. Subnormals flush to zero. Man=0, Exp=0, sign preserved.
  - exp all-ones, frac==0: Class 2. Man={1,frac}, Exp=0.
  - exp all-ones, frac!=0: Class 3. Man={1,frac}, Exp=0.
  - Otherwise: Class 1. Exp = exp − ExpConst, sign-extended. Man = {1'b1, frac}.
- Busy_o = S1 valid OR S2 valid.
- Reset mid-operation: in-flight words are discarded and no result is emitted for them. A requester whose request was already acked must not expect a result.
- Simultaneous final-pop and new grant: allowed in the same cycle. There is no bubble.

Decomposition:
- Shared package (fp_pkg) holds:
  - Class encodings: CLASS_ZERO, CLASS_NORM, CLASS_INF, CLASS_NAN.
  - The ExpConst function.
  - The field-slicing helpers for sign, exponent and mantissa.
- One sub-module, fp_unpack: a combinational decoder from a packed word to {sign, exp, man, class}. It is instantiated between S1 and S2 and is reusable elsewhere.
- The arbiter and pipeline control stay in the top module.

Test Plan:
- Single requester 0 sends 0x3F800000 → Ack_o=0001 at cycle N. At N+2: Valid_o=1, Id=0, Sign=0, Exp=0, Man=0x800000, Class=1.
- Requester 2 sends 0xC0400000 → Id=2, Sign=1, Exp=+1, Man=0xC00000, Class=1. Requester 1 sends 0x00800000 → Exp=−126, Class=1.
- Special values:
  - 0x7F800000 → Class=2.
  - 0xFFC00000 → Class=3, Sign=1.
  - 0x00000001 (subnormal) → Class=0, Man=0.
  - 0x80000000 → Class=0, Sign=1.
- All four requesters hold DataNd_i continuously → Ack order 0,1,2,3,0,1… on consecutive cycles, and result Ids follow the same order two cycles later.
- Stall: Rdy_i held low for 5 cycles with results pending → outputs frozen, at most 2 words in flight, and no Ack_o after S1 fills. When Rdy_i rises, results drain in order with none lost or duplicated.
- Assert Rst_i for one cycle with both stages full → next cycle Valid_o=0, Busy_o=0, pointer=0. The first post-reset grant goes to the lowest requesting index.
